lmsm_sequencer: RTL and testbench
=================================

# lmsm_sequencer

Multi-register load/store sequencer for the multicycle core's LM/SM instructions. It sits directly upstream of the 64×16 unified memory. It takes a base address and an 8-bit register list from the control FSM and walks the list one register at a time. For each selected register it drives the memory's 6-bit address and its active-low read/write strobes, and moves data between memory and the register file. The core control stalls on `busy` and resumes on `done`.

## Interface
- No parameters; widths are fixed to the memory (6-bit address, 16-bit data) and the 8-entry register file.
- `clk`  in  1  system clock; the sequencer acts on posedge, the memory samples on negedge of the same clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request, sampled only in IDLE
- `is_store`  in  1  1 = SM (registers→memory), 0 = LM (memory→registers); latched at start
- `base_addr`  in  16  start address; bits [5:0] are latched at start, upper bits ignored
- `reg_list`  in  8  bit i selects Ri; latched at start
- `mem_addr`  out  6  memory address
- `mem_read_n`  out  1  active-low read strobe
- `mem_write_n`  out  1  active-low write strobe
- `mem_wdata`  out  16  store data
- `mem_rdata`  in  16  memory `out` register
- `rf_raddr`  out  3  register-file read index
- `rf_rdata`  in  16  register-file read data (combinational)
- `rf_waddr`  out  3  register-file write index
- `rf_wdata`  out  16  register-file write data
- `rf_we`  out  1  register-file write enable
- `busy`  out  1  operation in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- Internal registers: `state`, `mask[7:0]`, `ptr[5:0]`, `op`.
- `idx` is the index of the lowest set bit of `mask` (priority encoder). Registers are always processed in ascending order R0→R7, at ascending addresses.
- IDLE, when `start`=1:
  - latch `mask`=`reg_list`, `ptr`=`base_addr[5:0]`, `op`=`is_store`.
  - go to DONE if `reg_list`==0, otherwise go to ACCESS.
- ACCESS, LM:
  - `mem_addr`=`ptr`, `mem_read_n`=0.
  - next state LOAD_WB.
- ACCESS, SM:
  - `rf_raddr`=`idx`, `mem_addr`=`ptr`, `mem_wdata`=`rf_rdata`, `mem_write_n`=0.
  - clear `mask[idx]` and increment `ptr`.
  - next state DONE if the remaining mask is 0, otherwise stay in ACCESS.
- LOAD_WB:
  - `rf_we`=1, `rf_waddr`=`idx`, `rf_wdata`=`mem_rdata`.
  - clear `mask[idx]` and increment `ptr`.
  - next state DONE if the remaining mask is 0, otherwise ACCESS.
- DONE: `done`=1, then return to IDLE.
- `busy`=1 in ACCESS, LOAD_WB and DONE; 0 in IDLE.
- `ptr` is 6 bits and wraps 63→0 with no error.
- `start` is ignored while not in IDLE.
- Strobe and enable outputs (`mem_read_n`, `mem_write_n`, `rf_we`, `done`, `busy`) are decoded from registered state only; they have no path from `start`/`reg_list`.
- `mem_read_n` and `mem_write_n` are never both 0.
- Outside ACCESS both strobes are 1, so the memory `out` register holds its value.

## Timing
- Reset values:
  - state IDLE, `mask`=0, `ptr`=0.
  - `mem_addr`=0, `mem_read_n`=1, `mem_write_n`=1, `mem_wdata`=0.
  - `rf_raddr`=0, `rf_waddr`=0, `rf_wdata`=0, `rf_we`=0.
  - `busy`=0, `done`=0.
- Take the edge that samples `start` as edge 0.
  - LM with N selected registers: ACCESS/LOAD_WB alternate over cycles 1..2N; `done` is high in cycle 2N+1.
  - SM with N selected registers: one store per cycle over cycles 1..N; `done` is high in cycle N+1.
  - Empty list: `done` is high in cycle 1 and no memory or register-file access occurs.
- Memory handshake:
  - Address and strobe are stable from the posedge; the memory captures them at the following negedge.
  - For LM, `mem_rdata` is valid at the next posedge, i.e. throughout LOAD_WB.
  - For SM, `rf_rdata` settles before the negedge write.
- `rst`=1 in any state returns to IDLE at that edge with all outputs at reset values. No further strobes are issued; a partially completed transfer is abandoned.
- `start`=1 in the same cycle as `rst`=1: reset wins and `start` is dropped.
- `start`=1 during the DONE cycle is ignored; a new request must be issued from IDLE.

## Test plan
- LM, base=2, reg_list=0b00000101, mem[2]=16'h0002, mem[3]=16'h0003 → exactly one `mem_read_n` low pulse per register (addr 2 in cycle 1, addr 3 in cycle 3); R0←0002 in cycle 2, R2←0003 in cycle 4; `done` in cycle 5.
- SM, base=10, reg_list=0b10000011, R0=AAAA, R1=BBBB, R7=7777 → `mem_write_n`=0 in cycles 1–3 at addr 10/11/12 with data AAAA/BBBB/7777; `done` in cycle 4; `rf_we` never asserted.
- Wrap: LM, base=16'hFFFE (latched ptr=62), reg_list=8'hFF → addresses 62,63,0,1,…,5 in order; `done` in cycle 17.
- Empty list: SM, reg_list=0 → `busy` high only in cycle 1, `done` in cycle 1, both strobes stay 1.
- `start` pulsed while busy during an LM of 3 registers → ignored; exactly 3 reads occur.
- `rst` asserted in the second LOAD_WB of a 4-register LM → next cycle IDLE, strobes=1, `rf_we`=0, `done` never pulses; a fresh `start` then completes normally.

Source files
------------

// File: rtl/lmsm_sequencer_if.sv
// Memory and register-file bus of the LM/SM sequencer.
// master: sequencer side (addresses, strobes, write data); slave: memory/RF side (read data).
interface lmsm_sequencer_if;
  logic [5:0]  mem_addr;
  logic        mem_read_n;
  logic        mem_write_n;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_we;

  modport master (
    output mem_addr, mem_read_n, mem_write_n, mem_wdata,
    output rf_raddr, rf_waddr, rf_wdata, rf_we,
    input  mem_rdata, rf_rdata
  );

  modport slave (
    input  mem_addr, mem_read_n, mem_write_n, mem_wdata,
    input  rf_raddr, rf_waddr, rf_wdata, rf_we,
    output mem_rdata, rf_rdata
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register list, one memory access per register.
// Ports: clk, rst (sync high), start/is_store/base_addr/reg_list in, busy/done out, bus (master).
module lmsm_sequencer (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_store,
  input  logic [15:0]         base_addr,
  input  logic [7:0]          reg_list,
  lmsm_sequencer_if.master    bus,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_LOAD_WB,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  mask, mask_n;
  logic [5:0]  ptr, ptr_n;
  logic        op, op_n;
  logic [2:0]  idx;
  logic [7:0]  rest;

  // lowest set bit of mask wins
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = i[2:0];
    end
  end

  assign rest = mask & ~(8'd1 << idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      mask  <= '0;
      ptr   <= '0;
      op    <= 1'b0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      ptr   <= ptr_n;
      op    <= op_n;
    end
  end

  always_comb begin
    state_n         = state;
    mask_n          = mask;
    ptr_n           = ptr;
    op_n            = op;
    bus.mem_addr    = '0;
    bus.mem_read_n  = 1'b1;
    bus.mem_write_n = 1'b1;
    bus.mem_wdata   = '0;
    bus.rf_raddr    = '0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    bus.rf_we       = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          mask_n  = reg_list;
          ptr_n   = base_addr[5:0];
          op_n    = is_store;
          state_n = (reg_list == 8'd0) ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        bus.mem_addr = ptr;
        if (op) begin
          bus.rf_raddr    = idx;
          bus.mem_wdata   = bus.rf_rdata;
          bus.mem_write_n = 1'b0;
          mask_n          = rest;
          ptr_n           = ptr + 6'd1;
          state_n         = (rest == 8'd0) ? S_DONE : S_ACCESS;
        end else begin
          bus.mem_read_n = 1'b0;
          state_n        = S_LOAD_WB;
        end
      end
      S_LOAD_WB: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = idx;
        bus.rf_wdata = bus.mem_rdata;
        mask_n       = rest;
        ptr_n        = ptr + 6'd1;
        state_n      = (rest == 8'd0) ? S_DONE : S_ACCESS;
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Testbench for lmsm_sequencer: memory/RF environment plus a transfer-level reference model.
// Per-cycle expectations derived from register-list arithmetic; final memory/RF compared to shadows.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_list;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  lmsm_sequencer_if bus ();

  lmsm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .reg_list  (reg_list),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [64];
  logic [15:0] rf  [8];
  logic [15:0] smem [64];
  logic [15:0] srf  [8];
  logic        pl_mwe = 1'b0;
  logic        pl_rwe = 1'b0;
  logic [5:0]  pl_a = '0;
  logic [15:0] pl_d = '0;

  assign bus.rf_rdata = rf[bus.rf_raddr];

  always @(negedge clk) begin
    if (pl_mwe) mem[pl_a] <= pl_d;
    else begin
      if (!bus.mem_read_n) bus.mem_rdata <= mem[bus.mem_addr];
      if (!bus.mem_write_n) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    else if (pl_rwe) rf[pl_a[2:0]] <= pl_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke_mem(input logic [5:0] a, input logic [15:0] d);
    smem[a] = d;
    pl_a = a; pl_d = d; pl_mwe = 1'b1;
    @(negedge clk); #1;
    pl_mwe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic poke_rf(input logic [2:0] r, input logic [15:0] d);
    srf[r] = d;
    pl_a = {3'd0, r}; pl_d = d; pl_rwe = 1'b1;
    @(posedge clk); #1;
    pl_rwe = 1'b0;
  endtask

  // rst_at: cycle during which rst is held (0 = none); poke: cycle with a stray start
  task automatic run_op(input bit st, input logic [15:0] base, input logic [7:0] list,
                        input int rst_at, input int poke);
    logic        e_busy [40];
    logic        e_done [40];
    logic        e_rn   [40];
    logic        e_wn   [40];
    logic        e_we   [40];
    logic [5:0]  e_addr [40];
    logic [15:0] e_data [40];
    logic [2:0]  e_reg  [40];
    int n, k, total, last, c;
    logic [5:0] a;
    for (int i = 0; i < 40; i++) begin
      e_busy[i] = 1'b0; e_done[i] = 1'b0;
      e_rn[i] = 1'b1; e_wn[i] = 1'b1; e_we[i] = 1'b0;
      e_addr[i] = '0; e_data[i] = '0; e_reg[i] = '0;
    end
    n = $countones(list);
    total = st ? n + 1 : 2 * n + 1;
    last = (rst_at > 0) ? rst_at : total;
    for (int i = 1; i <= total; i++) begin
      e_busy[i] = (i <= last);
      e_done[i] = (i == total) && (i <= last);
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (list[i]) begin
        a = base[5:0] + 6'(k);
        if (st) begin
          c = k + 1;
          if (c <= last) begin
            e_wn[c] = 1'b0; e_addr[c] = a; e_data[c] = srf[i];
            smem[a] = srf[i];
          end
        end else begin
          c = 2 * k + 1;
          if (c <= last) begin
            e_rn[c] = 1'b0; e_addr[c] = a;
          end
          if (c + 1 <= last) begin
            e_we[c + 1] = 1'b1; e_reg[c + 1] = 3'(i);
            e_data[c + 1] = smem[a];
            srf[i] = smem[a];
          end
        end
        k++;
      end
    end
    is_store = st; base_addr = base; reg_list = list; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom);
    reg_list = 8'($urandom);
    is_store = 1'($urandom);
    for (int i = 1; i <= total + 2; i++) begin
      chk($sformatf("c%0d busy", i), 32'(busy), 32'(e_busy[i]));
      chk($sformatf("c%0d done", i), 32'(done), 32'(e_done[i]));
      chk($sformatf("c%0d read_n", i), 32'(bus.mem_read_n), 32'(e_rn[i]));
      chk($sformatf("c%0d write_n", i), 32'(bus.mem_write_n), 32'(e_wn[i]));
      chk($sformatf("c%0d rf_we", i), 32'(bus.rf_we), 32'(e_we[i]));
      if (!e_rn[i] || !e_wn[i])
        chk($sformatf("c%0d mem_addr", i), 32'(bus.mem_addr), 32'(e_addr[i]));
      if (!e_wn[i])
        chk($sformatf("c%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(e_data[i]));
      if (e_we[i]) begin
        chk($sformatf("c%0d rf_waddr", i), 32'(bus.rf_waddr), 32'(e_reg[i]));
        chk($sformatf("c%0d rf_wdata", i), 32'(bus.rf_wdata), 32'(e_data[i]));
      end
      if (i == rst_at) rst = 1'b1;
      if (i == poke) start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;
    end
    for (int r = 0; r < 8; r++)
      chk($sformatf("rf[%0d]", r), 32'(rf[r]), 32'(srf[r]));
    for (int m = 0; m < 64; m++)
      chk($sformatf("mem[%0d]", m), 32'(mem[m]), 32'(smem[m]));
  endtask

  initial begin
    int p;
    rst = 1'b1; start = 1'b1; is_store = 1'b0;
    base_addr = 16'h0005; reg_list = 8'h0F;
    @(posedge clk); @(posedge clk); #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst read_n", 32'(bus.mem_read_n), 32'd1);
    chk("rst write_n", 32'(bus.mem_write_n), 32'd1);
    chk("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst rf_raddr", 32'(bus.rf_raddr), 32'd0);
    chk("rst rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("rst rf_wdata", 32'(bus.rf_wdata), 32'd0);
    chk("rst rf_we", 32'(bus.rf_we), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("start dropped in rst", 32'(busy), 32'd0);

    for (int m = 0; m < 64; m++) poke_mem(6'(m), 16'($urandom));
    for (int r = 0; r < 8; r++) poke_rf(3'(r), 16'($urandom));

    poke_mem(6'd2, 16'h0002);
    poke_mem(6'd3, 16'h0003);
    run_op(1'b0, 16'd2, 8'b0000_0101, 0, 0);

    poke_rf(3'd0, 16'hAAAA);
    poke_rf(3'd1, 16'hBBBB);
    poke_rf(3'd7, 16'h7777);
    run_op(1'b1, 16'd10, 8'b1000_0011, 0, 4);

    run_op(1'b0, 16'hFFFE, 8'hFF, 0, 0);
    run_op(1'b1, 16'h1234, 8'h00, 0, 0);
    run_op(1'b0, 16'd40, 8'b0010_0110, 0, 2);
    run_op(1'b0, 16'd20, 8'b0101_1010, 4, 0);
    run_op(1'b0, 16'd30, 8'b1100_0001, 0, 0);

    for (int t = 0; t < 12; t++) begin
      logic        st;
      logic [7:0]  l;
      st = 1'($urandom);
      l = 8'($urandom);
      p = $urandom_range(0, 3) == 0 ? $urandom_range(1, $countones(l) + 1) : 0;
      run_op(st, 16'($urandom), l, 0, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
